spi_reg_wctrl: RTL and testbench
================================

# spi_reg_wctrl

System-clock register-write controller sitting directly downstream of the SPI write buffer. It accepts write requests (address, data, single-cycle valid) after they have been brought into the `clk_sys` domain and queues them in a small FIFO. It then issues them one at a time to the register-file bus with a req/ack handshake. Misaligned addresses, queue overflow and bus timeouts are flagged in sticky error bits.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `TOUT_CYC`, 255: cycles `reg_req` may stay high without `reg_ack` before the access is abandoned; at least 2.

Ports (clock and reset first):
- `clk_sys` in 1: single system clock; all logic on its rising edge.
- `rst_sys` in 1: synchronous, active-high reset.
- `wr_vld` in 1: one-cycle write request, already synchronous to `clk_sys`.
- `wr_addr` in 16: byte address, sampled when `wr_vld` = 1.
- `wr_data` in 16: write data, sampled when `wr_vld` = 1.
- `wr_full` out 1: queue holds `DEPTH` entries.
- `wr_level` out $clog2(DEPTH)+1: current entry count.
- `reg_req` out 1: register-bus write request.
- `reg_addr` out 16: register address, stable while `reg_req` = 1.
- `reg_wdata` out 16: register data, stable while `reg_req` = 1.
- `reg_ack` in 1: one-cycle completion from the register file.
- `busy` out 1: queue non-empty or `reg_req` high.
- `err_clr` in 1: clears all sticky error bits.
- `ovf_err` out 1: sticky; a push was dropped because the queue was full.
- `align_err` out 1: sticky; an odd address was discarded.
- `tout_err` out 1: sticky; an access timed out.

## Operation
- Push: `wr_vld` = 1 with `wr_full` = 0 writes {`wr_addr`, `wr_data`} at the write pointer.
- Dropped push: `wr_vld` = 1 with `wr_full` = 1 drops the request and sets `ovf_err`. This holds even if a pop occurs in the same cycle; fullness is evaluated before the pop.
- Simultaneous push and pop (queue not full): level unchanged.
- Pointers: wrap modulo `DEPTH`. Level range is 0..`DEPTH`.
- FSM states are IDLE and REQ.
- IDLE, queue non-empty, head address even: load the head into `reg_addr`/`reg_wdata`, set `reg_req`, go to REQ.
- IDLE, queue non-empty, head address bit 0 = 1: pop and discard the head, set `align_err`, stay in IDLE.
- REQ, `reg_ack` = 1: clear `reg_req`, pop the head, clear the timeout counter, go to IDLE.
- REQ, no ack, counter = `TOUT_CYC`-1: clear `reg_req`, pop the head, set `tout_err`, go to IDLE.
- REQ, otherwise: counter increments.
- `reg_ack` while in IDLE is ignored.
- Error bits: `err_clr` clears all three; if a set and `err_clr` occur in the same cycle, the set wins.
- Reset values: all outputs 0, FSM in IDLE, pointers, level and counter 0. Reset mid-access drops `reg_req` the next cycle and discards all queued entries.

## Timing
- Push latency: `wr_vld` at cycle 0 into an empty queue gives `wr_level` = 1 and `busy` = 1 at cycle 1, and `reg_req` = 1 at cycle 2.
- Ack: `reg_ack` at cycle n gives `reg_req` = 0 and level decremented at cycle n+1. The next `reg_req` is at n+2 at the earliest.
- Throughput: one register write per 2 cycles maximum.
- Misaligned entry: consumes one IDLE cycle.
- Timeout: `reg_req` high at cycle k with no ack gives `reg_req` = 0 and `tout_err` = 1 at cycle k+`TOUT_CYC`.
- Ack on the final timeout cycle: counts as success; `tout_err` is not set.

## Structure
- Shared package `spi_pkg`: the FSM state enum (IDLE, REQ) and a write-entry struct {addr[15:0], data[15:0]}. The SPI write buffer uses the same struct.
- Sub-module `spi_wq_fifo`: synchronous FIFO parameterised by `DEPTH` and payload width, providing push, pop, full, empty and level.
- Top level: the FSM, timeout counter and error flags.

## Test plan
- Single write: push addr 0x0010, data 0x1234; ack 3 cycles after `reg_req` rises. Requires `reg_req` at cycle 2 with addr 0x0010 and data 0x1234, then `reg_req` = 0 and `busy` = 0 after the ack.
- Burst and overflow: push 0x0000, 0x0002, 0x0004, 0x0006 and 0x0008 on consecutive cycles with ack held low. Requires `wr_full` = 1, `ovf_err` = 1, the fifth write lost, and four bus writes in order once ack resumes.
- Misalignment: push 0x0003 then 0x0004. Requires `align_err` = 1 and only 0x0004 appearing on the bus.
- Timeout: `TOUT_CYC` = 8, push 0x0020, never ack. Requires `reg_req` to fall exactly 8 cycles after it rose, `tout_err` = 1 and the queue empty. Then assert `err_clr` and require `tout_err` = 0.
- Reset mid-access: 3 entries queued with `reg_req` high, assert `rst_sys` for one cycle. Requires all outputs 0 on the next cycle, and a late `reg_ack` after reset has no effect.

Source files
------------

// File: rtl/spi_pkg.sv
// Types shared between the SPI write buffer and the register-write controller.
package spi_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } wctrl_state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_entry_t;

  localparam int ENTRY_W = $bits(wr_entry_t);

endpackage

// File: rtl/spi_reg_wctrl_if.sv
// Write-request and register-bus signals of spi_reg_wctrl; "slave" is the controller side.
interface spi_reg_wctrl_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          wr_vld;
  logic [15:0]   wr_addr;
  logic [15:0]   wr_data;
  logic          wr_full;
  logic [LW-1:0] wr_level;
  logic          reg_req;
  logic [15:0]   reg_addr;
  logic [15:0]   reg_wdata;
  logic          reg_ack;
  logic          busy;
  logic          err_clr;
  logic          ovf_err;
  logic          align_err;
  logic          tout_err;

  modport master (
    output wr_vld, wr_addr, wr_data, reg_ack, err_clr,
    input  wr_full, wr_level, reg_req, reg_addr, reg_wdata, busy,
    input  ovf_err, align_err, tout_err
  );

  modport slave (
    input  wr_vld, wr_addr, wr_data, reg_ack, err_clr,
    output wr_full, wr_level, reg_req, reg_addr, reg_wdata, busy,
    output ovf_err, align_err, tout_err
  );

endinterface

// File: rtl/spi_wq_fifo.sv
// Synchronous FIFO, DEPTH a power of two; push when full and pop when empty are ignored.
// Head is read combinationally from storage, level/full/empty come straight from registers.
module spi_wq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + LW'(1);
    else if (!do_push && do_pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/spi_reg_wctrl.sv
// Queues SPI register writes and issues them one at a time on a req/ack register bus.
// Odd addresses are discarded, overflowing pushes dropped, unacked requests abandoned after TOUT_CYC cycles.
module spi_reg_wctrl
  import spi_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int TOUT_CYC = 255
) (
  input  logic            clk_sys,
  input  logic            rst_sys,
  spi_reg_wctrl_if.slave  bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(TOUT_CYC);

  wr_entry_t     push_ent;
  wr_entry_t     head;
  logic          full, empty;
  logic [LW-1:0] level;
  logic          push, pop;

  wctrl_state_e  state_q;
  logic          req_q;
  logic [15:0]   addr_q, wdata_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q, ovf_d;
  logic          align_q, align_d;
  logic          tout_q, tout_d;

  logic          cnt_last, ack_done, align_set, tout_set, ovf_set;

  assign push_ent = '{addr: bus.wr_addr, data: bus.wr_data};
  assign push     = bus.wr_vld && !full;

  spi_wq_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk_i      (clk_sys),
    .rst_i      (rst_sys),
    .push_i     (push),
    .push_dat_i (push_ent),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level)
  );

  // Ack on the last allowed cycle wins over the timeout.
  assign cnt_last  = (cnt_q == CW'(TOUT_CYC - 1));
  assign ack_done  = (state_q == REQ) && bus.reg_ack;
  assign tout_set  = (state_q == REQ) && !bus.reg_ack && cnt_last;
  assign align_set = (state_q == IDLE) && !empty && head.addr[0];
  assign ovf_set   = bus.wr_vld && full;
  assign pop       = ack_done || tout_set || align_set;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty && !head.addr[0]) begin
            addr_q  <= head.addr;
            wdata_q <= head.data;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (bus.reg_ack || cnt_last) begin
            req_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ovf_d   = ovf_set   || (ovf_q   && !bus.err_clr);
  assign align_d = align_set || (align_q && !bus.err_clr);
  assign tout_d  = tout_set  || (tout_q  && !bus.err_clr);

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      ovf_q   <= 1'b0;
      align_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      ovf_q   <= ovf_d;
      align_q <= align_d;
      tout_q  <= tout_d;
    end
  end

  assign bus.wr_full   = full;
  assign bus.wr_level  = level;
  assign bus.reg_req   = req_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.busy      = !empty || req_q;
  assign bus.ovf_err   = ovf_q;
  assign bus.align_err = align_q;
  assign bus.tout_err  = tout_q;

endmodule

// File: tb/tb_spi_reg_wctrl.sv
// Directed bench for spi_reg_wctrl with a queue-level reference model checked every cycle.
module tb_spi_reg_wctrl;
  localparam int DEPTH = 4;
  localparam int TOUT  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_reg_wctrl_if #(.DEPTH(DEPTH)) bus ();

  spi_reg_wctrl #(.DEPTH(DEPTH), .TOUT_CYC(TOUT)) dut (
    .clk_sys (clk),
    .rst_sys (rst),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending writes as a plain queue, plus the one in flight.
  logic [31:0] mq[$];
  logic [15:0] obs[$];
  bit          m_ok = 0;
  bit          m_req, m_ovf, m_align, m_tout;
  int          m_age;
  logic [15:0] m_addr, m_data;
  bit          was_full, s_ovf, s_align, s_tout;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_req = 0; m_age = 0; m_ovf = 0; m_align = 0; m_tout = 0;
      m_addr = '0; m_data = '0;
      m_ok = 1;
    end else begin
      was_full = (mq.size() == DEPTH);
      s_ovf = 0; s_align = 0; s_tout = 0;
      if (m_req) begin
        if (bus.reg_ack) begin
          void'(mq.pop_front()); m_req = 0;
        end else if (m_age == TOUT - 1) begin
          void'(mq.pop_front()); m_req = 0; s_tout = 1;
        end else begin
          m_age++;
        end
      end else if (mq.size() > 0) begin
        if (mq[0][16]) begin
          void'(mq.pop_front()); s_align = 1;
        end else begin
          m_req = 1; m_age = 0; m_addr = mq[0][31:16]; m_data = mq[0][15:0];
        end
      end
      if (bus.wr_vld) begin
        if (was_full) s_ovf = 1;
        else mq.push_back({bus.wr_addr, bus.wr_data});
      end
      if (bus.err_clr) begin m_ovf = 0; m_align = 0; m_tout = 0; end
      if (s_ovf)   m_ovf = 1;
      if (s_align) m_align = 1;
      if (s_tout)  m_tout = 1;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("level",   32'(bus.wr_level), 32'(mq.size()));
      chk("full",    32'(bus.wr_full),  32'(mq.size() == DEPTH));
      chk("busy",    32'(bus.busy),     32'(mq.size() > 0 || m_req));
      chk("req",     32'(bus.reg_req),  32'(m_req));
      chk("ovf",     32'(bus.ovf_err),  32'(m_ovf));
      chk("align",   32'(bus.align_err),32'(m_align));
      chk("tout",    32'(bus.tout_err), 32'(m_tout));
      if (m_req) begin
        chk("addr",  32'(bus.reg_addr),  32'(m_addr));
        chk("wdata", 32'(bus.reg_wdata), 32'(m_data));
      end
      if (bus.reg_req && bus.reg_ack) obs.push_back(bus.reg_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] d);
    bus.wr_vld  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_vld  = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int k = 0;
    while (!bus.reg_req && k < 20) begin tick(); k++; end
    chk(nm, 32'(bus.reg_req), 32'd1);
  endtask

  task automatic clr_err();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
  endtask

  int k;
  int n_obs;

  initial begin
    bus.wr_vld = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.reg_ack = 0; bus.err_clr = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_level", 32'(bus.wr_level), 32'd0);
    chk("rst_req",   32'(bus.reg_req),  32'd0);
    chk("rst_busy",  32'(bus.busy),     32'd0);
    tick();

    // Single write, ack three cycles after request rises.
    push(16'h0010, 16'h1234);
    chk("sw_level_c1", 32'(bus.wr_level), 32'd1);
    chk("sw_busy_c1",  32'(bus.busy),     32'd1);
    chk("sw_req_c1",   32'(bus.reg_req),  32'd0);
    tick();
    chk("sw_req_c2",   32'(bus.reg_req),   32'd1);
    chk("sw_addr_c2",  32'(bus.reg_addr),  32'h0010);
    chk("sw_data_c2",  32'(bus.reg_wdata), 32'h1234);
    tick(); tick(); tick();
    bus.reg_ack = 1'b1;
    tick();
    bus.reg_ack = 1'b0;
    chk("sw_req_done",  32'(bus.reg_req), 32'd0);
    chk("sw_busy_done", 32'(bus.busy),    32'd0);
    chk("sw_obs_n",     32'(obs.size()),  32'd1);
    if (obs.size() > 0) chk("sw_obs0", 32'(obs[0]), 32'h0010);
    tick();

    // Burst of five into a four-entry queue with ack low.
    obs.delete();
    for (int i = 0; i < 5; i++) push(16'(2 * i), 16'(16'hA000 + i));
    chk("bu_full",  32'(bus.wr_full),  32'd1);
    chk("bu_ovf",   32'(bus.ovf_err),  32'd1);
    chk("bu_level", 32'(bus.wr_level), 32'd4);
    bus.reg_ack = 1'b1;
    k = 0;
    while (bus.busy && k < 30) begin tick(); k++; end
    bus.reg_ack = 1'b0;
    chk("bu_drained", 32'(bus.busy), 32'd0);
    chk("bu_obs_n",   32'(obs.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < obs.size()) chk("bu_obs", 32'(obs[i]), 32'(2 * i));
    clr_err();
    chk("bu_ovf_clr", 32'(bus.ovf_err), 32'd0);
    tick();

    // Odd address discarded; clear in the same cycle as the set must lose.
    obs.delete();
    push(16'h0003, 16'h0BAD);
    bus.err_clr = 1'b1;
    push(16'h0004, 16'h4444);
    bus.err_clr = 1'b0;
    chk("ma_align", 32'(bus.align_err), 32'd1);
    chk("ma_level", 32'(bus.wr_level),  32'd1);
    chk("ma_req",   32'(bus.reg_req),   32'd0);
    tick();
    chk("ma_req2",  32'(bus.reg_req),   32'd1);
    chk("ma_addr",  32'(bus.reg_addr),  32'h0004);
    bus.reg_ack = 1'b1;
    tick();
    bus.reg_ack = 1'b0;
    chk("ma_obs_n", 32'(obs.size()), 32'd1);
    if (obs.size() > 0) chk("ma_obs0", 32'(obs[0]), 32'h0004);
    clr_err();
    chk("ma_align_clr", 32'(bus.align_err), 32'd0);

    // Timeout: request must drop exactly TOUT cycles after it rose.
    push(16'h0020, 16'h5555);
    wait_req("to_rise");
    k = 0;
    while (bus.reg_req && k < 20) begin tick(); k++; end
    chk("to_len",   32'(k), 32'd8);
    chk("to_err",   32'(bus.tout_err), 32'd1);
    chk("to_level", 32'(bus.wr_level), 32'd0);
    chk("to_busy",  32'(bus.busy),     32'd0);
    clr_err();
    chk("to_clr",   32'(bus.tout_err), 32'd0);

    // Ack on the final allowed cycle is a success.
    obs.delete();
    push(16'h0022, 16'h6666);
    wait_req("ta_rise");
    for (int i = 0; i < TOUT - 1; i++) tick();
    chk("ta_still_req", 32'(bus.reg_req), 32'd1);
    bus.reg_ack = 1'b1;
    tick();
    bus.reg_ack = 1'b0;
    chk("ta_req", 32'(bus.reg_req),  32'd0);
    chk("ta_err", 32'(bus.tout_err), 32'd0);
    chk("ta_obs_n", 32'(obs.size()), 32'd1);
    if (obs.size() > 0) chk("ta_obs0", 32'(obs[0]), 32'h0022);
    tick();

    // Reset mid-access with three entries queued and an error pending.
    push(16'h0031, 16'h1111);
    push(16'h0040, 16'h2222);
    push(16'h0042, 16'h3333);
    push(16'h0044, 16'h4444);
    chk("rm_level", 32'(bus.wr_level),  32'd3);
    chk("rm_req",   32'(bus.reg_req),   32'd1);
    chk("rm_align", 32'(bus.align_err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm0_req",   32'(bus.reg_req),   32'd0);
    chk("rm0_level", 32'(bus.wr_level),  32'd0);
    chk("rm0_full",  32'(bus.wr_full),   32'd0);
    chk("rm0_busy",  32'(bus.busy),      32'd0);
    chk("rm0_ovf",   32'(bus.ovf_err),   32'd0);
    chk("rm0_align", 32'(bus.align_err), 32'd0);
    chk("rm0_tout",  32'(bus.tout_err),  32'd0);
    chk("rm0_addr",  32'(bus.reg_addr),  32'd0);
    chk("rm0_wdata", 32'(bus.reg_wdata), 32'd0);
    n_obs = obs.size();
    bus.reg_ack = 1'b1;
    tick();
    bus.reg_ack = 1'b0;
    chk("rm_late_req",  32'(bus.reg_req), 32'd0);
    chk("rm_late_busy", 32'(bus.busy),    32'd0);
    chk("rm_late_obs",  32'(obs.size()),  32'(n_obs));
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
